// File: rtl/fsa_sequencer.sv
// fsa_sequencer: one-hot instruction-step sequencer for the instruction decoder.
// Walks a NUM_STEPS-wide one-hot step vector, wraps early on decoder aborts at
// steps 7/9/11/13, and supports free-run, halt-at-boundary and single-step modes.
// fsa_out_prime is fsa_out delayed by one clock for pulse generation downstream.
module fsa_sequencer #(
    parameter int NUM_STEPS = 24,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 single_step,
    input  logic                 step_pulse,
    input  logic                 abort8,
    input  logic                 abort10,
    input  logic                 abort12,
    input  logic                 abort14,
    output logic [NUM_STEPS-1:0] fsa_out,
    output logic [NUM_STEPS-1:0] fsa_out_prime,
    output logic                 running,
    output logic                 inst_done,
    output logic [CNT_W-1:0]     inst_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NUM_STEPS-1:0] STEP0   = NUM_STEPS'(1);
    localparam logic [NUM_STEPS-1:0] VEC_ONE = NUM_STEPS'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    state_t               state;
    state_t               state_next;
    logic [NUM_STEPS-1:0] fsa_next;
    logic                 adv;
    logic                 last;
    logic                 onehot_ok;

    assign running = (state == RUN);

    // Step qualification: advance strobe, last-step detect and one-hot sanity.
    always_comb begin
        adv = single_step ? step_pulse : 1'b1;
        // Only one bit of fsa_out is ever set, so the earliest matching
        // abort step wins automatically; aborts at other steps are masked.
        last = fsa_out[NUM_STEPS-1]
             | (fsa_out[7]  & abort8)
             | (fsa_out[9]  & abort10)
             | (fsa_out[11] & abort12)
             | (fsa_out[13] & abort14);
        onehot_ok = (fsa_out != '0) && ((fsa_out & (fsa_out - VEC_ONE)) == '0);
    end

    // Next-state and next-step decode, with the instruction-boundary pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_next = state;
        fsa_next   = fsa_out;
        inst_done  = 1'b0;
        case (state)
            IDLE: begin
                fsa_next = '0;
                if (start) begin
                    state_next = RUN;
                    fsa_next   = STEP0;
                end
            end
            RUN: begin
                if (!onehot_ok) begin
                    // Unreachable corrupted vector: fall back to a clean IDLE.
                    state_next = IDLE;
                    fsa_next   = '0;
                end else if (adv) begin
                    if (last) begin
                        inst_done = 1'b1;
                        if (halt_req) begin
                            state_next = IDLE;
                            fsa_next   = '0;
                        end else begin
                            fsa_next = STEP0;
                        end
                    end else begin
                        fsa_next = fsa_out << 1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                fsa_next   = '0;
            end
        endcase
    end

    // State, step vector and its delayed copy.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values; fsa_out_prime relies on that.
        if (reset) begin
            state         <= IDLE;
            fsa_out       <= '0;
            fsa_out_prime <= '0;
        end else begin
            state         <= state_next;
            fsa_out       <= fsa_next;
            fsa_out_prime <= fsa_out;
        end
    end

    // Completed-instruction counter, wrapping silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_count <= '0;
        end else if (inst_done) begin
            inst_count <= inst_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fsa_sequencer.sv
// tb_fsa_sequencer: scoreboard bench for fsa_sequencer. A step-index reference
// model predicts every cycle's outputs; a separate monitor pops and compares.
// A second instance with a 4-bit counter exercises the counter wrap quickly.
module tb_fsa_sequencer;

    localparam int N = 24;

    logic         clk;
    logic         reset;
    logic         start, halt_req, single_step, step_pulse;
    logic         abort8, abort10, abort12, abort14;
    logic [N-1:0] fsa_out, fsa_out_prime;
    logic         running, inst_done;
    logic [15:0]  inst_count;
    logic [N-1:0] s_fsa_out, s_fsa_out_prime;
    logic         s_running, s_inst_done;
    logic [3:0]   s_inst_count;

    fsa_sequencer #(.NUM_STEPS(N), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .single_step(single_step), .step_pulse(step_pulse),
        .abort8(abort8), .abort10(abort10), .abort12(abort12), .abort14(abort14),
        .fsa_out(fsa_out), .fsa_out_prime(fsa_out_prime), .running(running),
        .inst_done(inst_done), .inst_count(inst_count)
    );

    fsa_sequencer #(.NUM_STEPS(N), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .single_step(single_step), .step_pulse(step_pulse),
        .abort8(abort8), .abort10(abort10), .abort12(abort12), .abort14(abort14),
        .fsa_out(s_fsa_out), .fsa_out_prime(s_fsa_out_prime), .running(s_running),
        .inst_done(s_inst_done), .inst_count(s_inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] fsa;
        logic [N-1:0] prime;
        logic         run;
        logic         done;
        logic [15:0]  count;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Stimulus for the next tick (copied onto the DUT pins at the negedge).
    logic d_reset, d_start, d_halt, d_ss, d_sp, d_a8, d_a10, d_a12, d_a14;

    // Reference model: step index (-1 = idle), delayed vector, instruction count.
    int           m_s     = -1;
    logic [N-1:0] m_prime = '0;
    logic [15:0]  m_count = '0;

    function automatic logic [N-1:0] vec_of(input int s);
        logic [N-1:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic is_last(input int s);
        return (s == N - 1) || (s == 7 && d_a8) || (s == 9 && d_a10) ||
               (s == 11 && d_a12) || (s == 13 && d_a14);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // One clock of stimulus: drive pins, predict this cycle, advance the model.
    task automatic tick();
        exp_t e;
        logic adv;
        logic done;
        @(negedge clk);
        reset = d_reset; start = d_start; halt_req = d_halt;
        single_step = d_ss; step_pulse = d_sp;
        abort8 = d_a8; abort10 = d_a10; abort12 = d_a12; abort14 = d_a14;
        #1;
        if (d_reset) begin
            m_s = -1; m_prime = '0; m_count = '0;
        end
        adv  = d_ss ? d_sp : 1'b1;
        done = !d_reset && (m_s >= 0) && adv && is_last(m_s);
        e.fsa = vec_of(m_s); e.prime = m_prime; e.run = (m_s >= 0);
        e.done = done; e.count = m_count;
        exp_q.push_back(e);
        if (!d_reset) begin
            m_prime = vec_of(m_s);
            if (m_s < 0) begin
                if (d_start) m_s = 0;
            end else if (adv) begin
                if (done) begin
                    m_count = m_count + 16'd1;
                    m_s = d_halt ? -1 : 0;
                end else begin
                    m_s = m_s + 1;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        d_reset = 0; d_start = 0; d_halt = 0; d_ss = 0; d_sp = 0;
        d_a8 = 0; d_a10 = 0; d_a12 = 0; d_a14 = 0;
    endtask

    task automatic pulse_start();
        d_start = 1; tick(); d_start = 0;
    endtask

    // Monitor: compares the oldest prediction against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check("fsa_out",       32'(fsa_out),       32'(e.fsa));
                check("fsa_out_prime", 32'(fsa_out_prime), 32'(e.prime));
                check("running",       32'(running),       32'(e.run));
                check("inst_done",     32'(inst_done),     32'(e.done));
                check("inst_count",    32'(inst_count),    32'(e.count));
                check("small_count",   32'(s_inst_count),  32'(e.count[3:0]));
                check("small_fsa_out", 32'(s_fsa_out),     32'(e.fsa));
            end
        end
    end

    initial begin
        reset = 1; start = 0; halt_req = 0; single_step = 0; step_pulse = 0;
        abort8 = 0; abort10 = 0; abort12 = 0; abort14 = 0;
        clear_inputs();
        d_reset = 1;
        repeat (2) tick();
        d_reset = 0;
        tick();

        // Full 24-step instruction, wrap, a few steps more.
        pulse_start();
        repeat (30) tick();

        // abort8 held: four 8-step instructions, plus margin.
        d_a8 = 1;
        repeat (34) tick();
        d_a8 = 0;
        while (m_s != 0) tick();

        // abort10 only at step 3 is ignored: full cycle.
        for (int i = 0; i < 26; i++) begin
            d_a10 = (m_s == 3);
            tick();
        end
        d_a10 = 0;

        // abort8 and abort14 together: step 7 wins.
        d_a8 = 1; d_a14 = 1;
        repeat (20) tick();
        d_a8 = 0; d_a14 = 0;

        // halt_req at step 5 with abort12: finish at step 11 then idle.
        for (int i = 0; i < 40 && m_s != 5; i++) tick();
        d_halt = 1; d_a12 = 1;
        for (int i = 0; i < 40 && m_s >= 0; i++) tick();
        d_halt = 0; d_a12 = 0;
        repeat (3) tick();
        pulse_start();
        pulse_start();  // start while running is ignored
        repeat (4) tick();

        // Single-step with a pulse every third cycle.
        d_ss = 1;
        for (int i = 0; i < 45; i++) begin
            d_sp = (i % 3 == 2);
            tick();
        end
        d_ss = 0; d_sp = 0;

        // Reset mid-instruction at step 15.
        for (int i = 0; i < 40 && m_s != 15; i++) tick();
        d_reset = 1; tick(); tick();
        d_reset = 0; tick();
        pulse_start();
        repeat (5) tick();

        // Counter wrap on the 4-bit instance: 17 short instructions.
        d_a8 = 1;
        repeat (17 * 8 + 3) tick();
        d_a8 = 0;

        // Randomized mix of every input.
        for (int i = 0; i < 2500; i++) begin
            if (i % 120 == 0) d_ss = ($urandom_range(0, 2) == 0);
            d_start = ($urandom_range(0, 7) == 0);
            d_halt  = ($urandom_range(0, 15) == 0);
            d_sp    = ($urandom_range(0, 2) == 0);
            d_a8    = ($urandom_range(0, 5) == 0);
            d_a10   = ($urandom_range(0, 5) == 0);
            d_a12   = ($urandom_range(0, 5) == 0);
            d_a14   = ($urandom_range(0, 5) == 0);
            d_reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        clear_inputs();
        tick();

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
